// File: rtl/block_pe_param_if.sv
// Data-side bundle of the parametrised CGRA processing element: packed
// input ports with their valid qualifier, and the PE result with its valid.
interface block_pe_param_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic [WIDTH-1:0]        out0;
    logic                    out_valid;

    modport master (output in_data, output in_valid, input out0, input out_valid);
    modport slave  (input in_data, input in_valid, output out0, output out_valid);
endinterface

// File: rtl/block_pe_param.sv
// Parametrised CGRA PE: operand crossbar with feedback, 8-op ALU, scratch RAM,
// serial config chain. Optional power-on RAM clear under macro PE_MEM_CLEAR_EN.
module block_pe_param #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             config_en,
    input  logic             config_in,
    output logic             config_out,
    block_pe_param_if.slave  dp,
    output logic             mem_busy
);
    localparam int SEL_W  = $clog2(NUM_IN + 2);
    localparam int AW     = $clog2(DEPTH);
    localparam int CFG_W  = 6 + 2 * SEL_W;
    localparam int SH_W   = $clog2(WIDTH);
    localparam int CAND_N = 2 ** SEL_W;

    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] mem_q, mem_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] ram_q [DEPTH];

    logic [2:0]       op_s;
    logic [SEL_W-1:0] sel_a_s, sel_b_s;
    logic [1:0]       mem_mode_s;
    logic             out_sel_s;
    logic [WIDTH-1:0] cand_s [CAND_N];
    logic [WIDTH-1:0] a_s, b_s, alu_res_s;
    logic [AW-1:0]    addr_s, clr_addr_s;
    logic             busy_s, fire_s;
    logic             ram_we_s;
    logic [AW-1:0]    ram_waddr_s;
    logic [WIDTH-1:0] ram_wdata_s;

    assign op_s       = cfg_q[2:0];
    assign sel_a_s    = cfg_q[3 +: SEL_W];
    assign sel_b_s    = cfg_q[3 + SEL_W +: SEL_W];
    assign mem_mode_s = cfg_q[3 + 2 * SEL_W +: 2];
    assign out_sel_s  = cfg_q[CFG_W-1];

    // Crossbar candidates: input ports, then alu_q / mem_q feedback, unused codes read 0.
    for (genvar k = 0; k < CAND_N; k++) begin : g_cand
        if (k < NUM_IN) begin : g_in
            assign cand_s[k] = dp.in_data[k*WIDTH +: WIDTH];
        end else if (k == NUM_IN) begin : g_alu
            assign cand_s[k] = alu_q;
        end else if (k == NUM_IN + 1) begin : g_mem
            assign cand_s[k] = mem_q;
        end else begin : g_zero
            assign cand_s[k] = '0;
        end
    end

    assign a_s    = cand_s[sel_a_s];
    assign b_s    = cand_s[sel_b_s];
    assign addr_s = b_s[AW-1:0];
    assign fire_s = dp.in_valid & ~config_en & ~busy_s;

`ifdef PE_MEM_CLEAR_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clr_busy_q, clr_busy_d;

    // Clear sequencer next state: one word per cycle, done after the last address.
    always_comb begin
        clr_cnt_d  = clr_cnt_q;
        clr_busy_d = clr_busy_q;
        if (clr_busy_q) begin
            clr_cnt_d  = clr_cnt_q + AW'(1);
            clr_busy_d = (clr_cnt_q != {AW{1'b1}});
        end else begin
            clr_cnt_d  = clr_cnt_q;
            clr_busy_d = 1'b0;
        end
    end

    // Clear sequencer registers; reset (re)starts the walk from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b1;
        end else begin
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign busy_s     = clr_busy_q;
    assign clr_addr_s = clr_cnt_q;
`else
    assign busy_s     = 1'b0;
    assign clr_addr_s = '0;
`endif

    assign mem_busy = busy_s;

    // ALU: unsigned, modulo 2^WIDTH.
    always_comb begin
        alu_res_s = '0;
        case (op_s)
            3'd0:    alu_res_s = a_s + b_s;
            3'd1:    alu_res_s = a_s - b_s;
            3'd2:    alu_res_s = a_s & b_s;
            3'd3:    alu_res_s = a_s | b_s;
            3'd4:    alu_res_s = a_s ^ b_s;
            3'd5:    alu_res_s = a_s << b_s[SH_W-1:0];
            3'd6:    alu_res_s = a_s >> b_s[SH_W-1:0];
            3'd7:    alu_res_s = a_s * b_s;
            default: alu_res_s = '0;
        endcase
    end

    // RAM write port shared by the clear walk and fired write operations.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = addr_s;
        ram_wdata_s = a_s;
        if (reset) begin
            ram_we_s = 1'b0;
        end else if (busy_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_addr_s;
            ram_wdata_s = '0;
        end else if (fire_s && (mem_mode_s == 2'b10)) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // Scratch RAM storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Datapath next state: config shift, and result/read capture only on fire.
    always_comb begin
        cfg_d       = cfg_q;
        alu_d       = alu_q;
        mem_d       = mem_q;
        out_valid_d = fire_s;
        if (config_en) begin
            cfg_d = {cfg_q[CFG_W-2:0], config_in};
        end else begin
            cfg_d = cfg_q;
        end
        if (fire_s) begin
            alu_d = alu_res_s;
            if (mem_mode_s == 2'b01) begin
                mem_d = ram_q[addr_s];
            end else begin
                mem_d = mem_q;
            end
        end else begin
            alu_d = alu_q;
            mem_d = mem_q;
        end
    end

    // Datapath registers; reset wins over config_en and in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q       <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            alu_q       <= alu_d;
            mem_q       <= mem_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dp.out0      = out_sel_s ? mem_q : alu_q;
    assign dp.out_valid = out_valid_q;
    assign config_out   = cfg_q[CFG_W-1];
endmodule

// File: tb/tb_block_pe_param.sv
// Randomised and directed bench for block_pe_param (default parameters) against
// a field-level reference model; also covers PE_MEM_CLEAR_EN when defined.
module tb_block_pe_param;
    logic clk = 1'b0;
    logic reset, config_en, config_in, config_out, mem_busy;

    block_pe_param_if #(.WIDTH(32), .NUM_IN(2)) pe_if ();

    block_pe_param #(.WIDTH(32), .NUM_IN(2), .DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .config_en  (config_en),
        .config_in  (config_in),
        .config_out (config_out),
        .dp         (pe_if),
        .mem_busy   (mem_busy)
    );

    always #5 clk = ~clk;

`ifdef PE_MEM_CLEAR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model state
    int        m_cfg;
    bit [31:0] m_alu, m_memq;
    bit [31:0] m_mem [16];
    bit        m_ov, m_busy;
    int        m_cnt;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit [31:0] alu_ref(input int op, input bit [31:0] a, input bit [31:0] b);
        longint unsigned x;
        longint unsigned la = a;
        longint unsigned lb = b;
        case (op)
            0: x = la + lb;
            1: x = la + 64'h1_0000_0000 - lb;
            2: x = la & lb;
            3: x = la | lb;
            4: x = la ^ lb;
            5: x = la << (lb % 32);
            6: x = la >> (lb % 32);
            default: x = la * lb;
        endcase
        return 32'(x % 64'h1_0000_0000);
    endfunction

    function automatic bit [31:0] opnd(input int sel, input bit [31:0] i0, input bit [31:0] i1);
        if (sel == 0) return i0;
        else if (sel == 1) return i1;
        else if (sel == 2) return m_alu;
        else return m_memq;
    endfunction

    task automatic tick(input bit r, input bit ce, input bit ci, input bit iv,
                        input bit [31:0] i0, input bit [31:0] i1);
        bit [31:0] a, b;
        int mode, addr;
        bit fire;
        reset = r; config_en = ce; config_in = ci;
        pe_if.in_valid = iv; pe_if.in_data = {i1, i0};
        @(posedge clk);
        if (r) begin
            m_cfg = 0; m_alu = 0; m_memq = 0; m_ov = 0;
            m_busy = HAS_CLR; m_cnt = 0;
        end else begin
            a    = opnd((m_cfg / 8) % 4, i0, i1);
            b    = opnd((m_cfg / 32) % 4, i0, i1);
            mode = (m_cfg / 128) % 4;
            addr = int'(b % 16);
            fire = iv && !ce && !m_busy;
            if (fire) begin
                if (mode == 2) m_mem[addr] = a;
                else if (mode == 1) m_memq = m_mem[addr];
                m_alu = alu_ref(m_cfg % 8, a, b);
            end
            if (ce) m_cfg = (m_cfg * 2 + int'(ci)) % 1024;
            if (m_busy) begin
                m_mem[m_cnt] = 0;
                m_cnt++;
                if (m_cnt == 16) m_busy = 0;
            end
            m_ov = fire;
        end
        #1;
        chk_val("out0", pe_if.out0, (m_cfg / 512) != 0 ? m_memq : m_alu);
        chk_val("out_valid", 32'(pe_if.out_valid), 32'(m_ov));
        chk_val("config_out", 32'(config_out), 32'(m_cfg / 512));
        chk_val("mem_busy", 32'(mem_busy), 32'(m_busy));
    endtask

    task automatic load_cfg(input bit [9:0] v, input bit iv);
        for (int i = 9; i >= 0; i--) tick(1'b0, 1'b1, v[i], iv, $urandom, $urandom);
    endtask

    task automatic settle();
        int n = 0;
        while (m_busy && n < 40) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            n++;
        end
    endtask

    initial begin
        int n;
        bit r, ce, iv;
        bit [31:0] i1;
        reset = 1'b1; config_en = 1'b0; config_in = 1'b0;
        pe_if.in_valid = 1'b0; pe_if.in_data = '0;
        #1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h5, 32'h7);
        chk_val("rst_out0", pe_if.out0, 32'h0);
        chk_val("rst_cfgout", 32'(config_out), 32'h0);
        settle();

        // preload every RAM word so later reads are defined
        load_cfg(10'h120, 1'b0);
        for (int a = 0; a < 16; a++) tick(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'(a));

        // each ALU op on in0, in1
        for (int op = 0; op < 8; op++) begin
            load_cfg(10'(op + 32), 1'b0);
            tick(1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom_range(0, 70));
        end

        load_cfg(10'h008, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2);
        chk_val("add_wrap", pe_if.out0, 32'h1);
        chk_val("add_valid", 32'(pe_if.out_valid), 32'h1);

        tick(1'b1, 1'b1, 1'b1, 1'b1, 32'h9, 32'h9);
        chk_val("rst_mid_out0", pe_if.out0, 32'h0);
        chk_val("rst_mid_valid", 32'(pe_if.out_valid), 32'h0);
        chk_val("rst_mid_cfg", 32'(config_out), 32'h0);
        settle();

        load_cfg(10'h010, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h5, 32'h0);
            chk_val("accum", pe_if.out0, 32'(5 * k));
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h5, 32'h0);
            chk_val("stall_valid", 32'(pe_if.out_valid), 32'h0);
            chk_val("stall_hold", pe_if.out0, 32'd20);
        end
        load_cfg(10'h010, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h5, 32'h0);
        chk_val("resume", pe_if.out0, 32'd25);

        load_cfg(10'h120, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 32'h3);
        load_cfg(10'h2A0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h3);
        chk_val("mem_rd", pe_if.out0, 32'hDEAD);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'd19);
        chk_val("mem_rd_wrap", pe_if.out0, 32'hDEAD);

`ifdef PE_MEM_CLEAR_EN
        load_cfg(10'h120, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h5);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        n = 0;
        while (mem_busy === 1'b1 && n < 40) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
            n++;
        end
        chk_val("clr_len", 32'(n), 32'd16);
        settle();
        load_cfg(10'h2A0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h5);
        chk_val("clr_rd", pe_if.out0, 32'h0);
`endif

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 29) == 0) load_cfg(10'($urandom), 1'($urandom));
            r  = ($urandom_range(0, 63) == 0);
            ce = ($urandom_range(0, 5) == 0);
            iv = 1'($urandom);
            i1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            tick(r, ce, 1'($urandom), iv, $urandom, i1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
